brew_controller: RTL

BREW_CONTROLLER -- requirements
Module: brew_controller

---
 rtl/brew_pkg.sv | 21 ++
 rtl/brew_tick_gen.sv | 26 ++
 rtl/brew_controller.sv | 132 +++++++++++++
 3 files changed

// File: rtl/brew_pkg.sv
// Shared state encodings and port-width helpers for the brew controller.
package brew_pkg;

  localparam logic [2:0] ST_OFF   = 3'd0;
  localparam logic [2:0] ST_IDLE  = 3'd1;
  localparam logic [2:0] ST_BREW  = 3'd2;
  localparam logic [2:0] ST_DONE  = 3'd3;
  localparam logic [2:0] ST_EMPTY = 3'd4;
  localparam logic [2:0] ST_FILL  = 3'd5;

  // One extra select bit so out-of-range drinks reach the block and get rejected,
  // even when N_DRINKS is a power of two.
  function automatic int sel_w(input int n_drinks);
    return $clog2(n_drinks) + 1;
  endfunction

  function automatic int cup_w(input int tank_cups);
    return $clog2(tank_cups + 1);
  endfunction

endpackage

// File: rtl/brew_tick_gen.sv
// Free-running divider producing a one-cycle tick every TICK_DIV clocks.
module brew_tick_gen #(
  parameter int TICK_DIV = 100_000_000
) (
  input  logic clk_100MHz,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] LAST = TW'(TICK_DIV - 1);

  logic [TW-1:0] cnt;

  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset)            cnt <= '0;
    else if (clear)       cnt <= '0;
    else if (cnt == LAST) cnt <= '0;
    else                  cnt <= cnt + 1'b1;
  end

  // Not gated by clear: the FSM uses the final tick of a phase to leave it.
  assign tick = (cnt == LAST);

endmodule

// File: rtl/brew_controller.sv
// Beverage machine sequencer: OFF/IDLE/BREW/DONE/EMPTY/FILL with tank cup accounting.
module brew_controller
  import brew_pkg::*;
#(
  parameter int N_DRINKS  = 4,
  parameter int TANK_CUPS = 7,
  parameter int BREW_SECS = 5,
  parameter int FILL_SECS = 3,
  parameter int TICK_DIV  = 100_000_000,
  localparam int SW = sel_w(N_DRINKS),
  localparam int CW = cup_w(TANK_CUPS)
) (
  input  logic                clk_100MHz,
  input  logic                reset,
  input  logic                enable,
  input  logic                brew_req,
  input  logic [SW-1:0]       drink_sel,
  input  logic                fill_req,
  output logic [2:0]          state,
  output logic [CW-1:0]       cup_count,
  output logic [N_DRINKS-1:0] valve,
  output logic [7:0]          progress,
  output logic                blink,
  output logic                done,
  output logic                reject
);

  localparam logic [CW-1:0]       FULL     = CW'(TANK_CUPS);
  localparam logic [SW-1:0]       NSEL     = SW'(N_DRINKS);
  localparam logic [31:0]         BREW_END = 32'(BREW_SECS - 1);
  localparam logic [31:0]         FILL_END = 32'(FILL_SECS - 1);
  localparam logic [N_DRINKS-1:0] ONE      = N_DRINKS'(1);

  logic [2:0]  next_state;
  logic        tick, clear, busy, any_req, sel_ok, start_brew;
  logic        done_n, reject_n;
  logic [31:0] elapsed;

  assign any_req = brew_req | fill_req;
  assign sel_ok  = (drink_sel < NSEL);
  assign busy    = (state == ST_BREW) || (state == ST_FILL);
  assign clear   = (next_state != state) &&
                   (next_state == ST_BREW || next_state == ST_FILL || next_state == ST_DONE);

  brew_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk_100MHz (clk_100MHz),
    .reset      (reset),
    .clear      (clear),
    .tick       (tick)
  );

  always_comb begin
    next_state = state;
    reject_n   = 1'b0;
    done_n     = 1'b0;
    start_brew = 1'b0;
    case (state)
      ST_OFF:
        if (enable) next_state = (cup_count != '0) ? ST_IDLE : ST_EMPTY;
      ST_IDLE:
        if (!enable) next_state = ST_OFF;
        else if (brew_req) begin
          // brew wins over a simultaneous fill; the fill is dropped
          if (sel_ok && cup_count != '0) begin
            next_state = ST_BREW;
            start_brew = 1'b1;
          end else reject_n = 1'b1;
        end else if (fill_req) begin
          if (cup_count < FULL) next_state = ST_FILL;
          else                  reject_n   = 1'b1;
        end
      ST_EMPTY:
        if (!enable)       next_state = ST_OFF;
        else if (fill_req) next_state = ST_FILL;
        else if (brew_req) reject_n   = 1'b1;
      ST_BREW: begin
        // enable is ignored here so a started brew always completes
        reject_n = any_req;
        if (tick && elapsed == BREW_END) begin
          next_state = ST_DONE;
          done_n     = 1'b1;
        end
      end
      ST_DONE:
        if (!enable) next_state = ST_OFF;
        else begin
          reject_n = any_req;
          if (tick) next_state = (cup_count != '0) ? ST_IDLE : ST_EMPTY;
        end
      ST_FILL: begin
        reject_n = any_req;
        if (tick && elapsed == FILL_END) next_state = enable ? ST_IDLE : ST_OFF;
      end
      default: next_state = ST_OFF;
    endcase
  end

  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      state     <= ST_OFF;
      cup_count <= FULL;
      valve     <= '0;
      progress  <= '0;
      blink     <= 1'b0;
      done      <= 1'b0;
      reject    <= 1'b0;
      elapsed   <= '0;
    end else begin
      state  <= next_state;
      done   <= done_n;
      reject <= reject_n;

      if (start_brew)                                cup_count <= cup_count - 1'b1;
      else if (state == ST_FILL && next_state != ST_FILL) cup_count <= FULL;

      if (start_brew)                valve <= ONE << drink_sel;
      else if (next_state != ST_BREW) valve <= '0;

      // phase-local tick bookkeeping restarts on every state change
      if (next_state != state || !busy) begin
        elapsed  <= '0;
        progress <= '0;
        blink    <= 1'b0;
      end else if (tick) begin
        elapsed <= elapsed + 1'b1;
        if (progress != 8'hFF) progress <= progress + 1'b1;
        blink <= ~blink;
      end
    end
  end

endmodule
